// File: rtl/pma_attr_stage.sv
// Two-stage physical-memory-attribute lookup: S1 compares the address against every
// rule window, S2 reduces the hit vectors into per-request attributes.
package pma_attr_pkg;
    localparam int unsigned NrMaxRules = 4;

    typedef struct packed {
        logic [31:0]                 NrNonIdempotentRules;
        logic [NrMaxRules-1:0][63:0] NonIdempotentAddrBase;
        logic [NrMaxRules-1:0][63:0] NonIdempotentLength;
        logic [31:0]                 NrExecuteRegionRules;
        logic [NrMaxRules-1:0][63:0] ExecuteRegionAddrBase;
        logic [NrMaxRules-1:0][63:0] ExecuteRegionLength;
        logic [31:0]                 NrCachedRegionRules;
        logic [NrMaxRules-1:0][63:0] CachedRegionAddrBase;
        logic [NrMaxRules-1:0][63:0] CachedRegionLength;
        logic                        DcacheSpmEn;
        logic [55:0]                 DcacheSpmBase;
        logic [55:0]                 DcacheSpmLength;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;
endpackage

module pma_attr_stage
    import pma_attr_pkg::*;
#(
    parameter cva6_cfg_t   CVA6Cfg = cva6_cfg_empty,
    parameter int unsigned IdWidth = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [63:0]        req_addr_i,
    input  logic               req_fetch_i,
    input  logic [IdWidth-1:0] req_id_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [IdWidth-1:0] rsp_id_o,
    output logic               rsp_cacheable_o,
    output logic               rsp_nonidem_o,
    output logic               rsp_exec_o,
    output logic               rsp_dspm_o,
    output logic               rsp_exec_fault_o,
    input  logic               clr_cnt_i,
    output logic [15:0]        fault_cnt_o
);

    // 65-bit end address so a window reaching 2^64 still covers the top address.
    function automatic logic f_in_range(input logic [63:0] i_addr,
                                        input logic [63:0] i_base,
                                        input logic [63:0] i_len);
        logic [64:0] w_end;
        w_end = {1'b0, i_base} + {1'b0, i_len};
        return ({1'b0, i_addr} >= {1'b0, i_base}) && ({1'b0, i_addr} < w_end);
    endfunction

    logic [NrMaxRules-1:0] w_nonidem_hit;
    logic [NrMaxRules-1:0] w_exec_hit;
    logic [NrMaxRules-1:0] w_cached_hit;
    logic                  w_dspm_hit;

    for (genvar gi = 0; gi < NrMaxRules; gi++) begin : g_rule
        assign w_nonidem_hit[gi] = (32'(gi) < CVA6Cfg.NrNonIdempotentRules) &&
            f_in_range(req_addr_i, CVA6Cfg.NonIdempotentAddrBase[gi], CVA6Cfg.NonIdempotentLength[gi]);
        assign w_exec_hit[gi] = (32'(gi) < CVA6Cfg.NrExecuteRegionRules) &&
            f_in_range(req_addr_i, CVA6Cfg.ExecuteRegionAddrBase[gi], CVA6Cfg.ExecuteRegionLength[gi]);
        assign w_cached_hit[gi] = (32'(gi) < CVA6Cfg.NrCachedRegionRules) &&
            f_in_range(req_addr_i, CVA6Cfg.CachedRegionAddrBase[gi], CVA6Cfg.CachedRegionLength[gi]);
    end

    assign w_dspm_hit = CVA6Cfg.DcacheSpmEn &&
        f_in_range(req_addr_i, 64'(CVA6Cfg.DcacheSpmBase), 64'(CVA6Cfg.DcacheSpmLength));

    logic                  r_s1_valid;
    logic                  r_s1_fetch;
    logic [IdWidth-1:0]    r_s1_id;
    logic [NrMaxRules-1:0] r_s1_nonidem;
    logic [NrMaxRules-1:0] r_s1_exec;
    logic [NrMaxRules-1:0] r_s1_cached;
    logic                  r_s1_dspm;

    logic                  r_s2_valid;
    logic [IdWidth-1:0]    r_s2_id;
    logic                  r_s2_cacheable;
    logic                  r_s2_nonidem;
    logic                  r_s2_exec;
    logic                  r_s2_dspm;
    logic                  r_s2_fault;
    logic [15:0]           r_fault_cnt;

    logic w_s2_adv;
    logic w_s1_adv;
    logic w_exec_red;
    logic w_cache_red;
    logic w_fault;
    logic w_rsp_fire;

    assign w_s2_adv    = !r_s2_valid || rsp_ready_i;
    assign w_s1_adv    = !r_s1_valid || w_s2_adv;
    assign req_ready_o = w_s1_adv && !flush_i;

    // With no execute rules every address is executable.
    assign w_exec_red  = (CVA6Cfg.NrExecuteRegionRules == 32'd0) ? 1'b1 : |r_s1_exec;
    assign w_cache_red = (|r_s1_cached) && !r_s1_dspm;
    assign w_fault     = r_s1_fetch && !w_exec_red;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid   <= 1'b0;
            r_s1_fetch   <= 1'b0;
            r_s1_id      <= '0;
            r_s1_nonidem <= '0;
            r_s1_exec    <= '0;
            r_s1_cached  <= '0;
            r_s1_dspm    <= 1'b0;
        end else begin
            if (flush_i) begin
                r_s1_valid <= 1'b0;
            end else if (w_s1_adv) begin
                r_s1_valid <= req_valid_i;
            end
            if (w_s1_adv) begin
                r_s1_fetch   <= req_fetch_i;
                r_s1_id      <= req_id_i;
                r_s1_nonidem <= w_nonidem_hit;
                r_s1_exec    <= w_exec_hit;
                r_s1_cached  <= w_cached_hit;
                r_s1_dspm    <= w_dspm_hit;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s2_valid     <= 1'b0;
            r_s2_id        <= '0;
            r_s2_cacheable <= 1'b0;
            r_s2_nonidem   <= 1'b0;
            r_s2_exec      <= 1'b0;
            r_s2_dspm      <= 1'b0;
            r_s2_fault     <= 1'b0;
        end else begin
            if (flush_i) begin
                r_s2_valid <= 1'b0;
            end else if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s2_adv) begin
                r_s2_id        <= r_s1_id;
                r_s2_cacheable <= w_cache_red;
                r_s2_nonidem   <= |r_s1_nonidem;
                r_s2_exec      <= w_exec_red;
                r_s2_dspm      <= r_s1_dspm;
                r_s2_fault     <= w_fault;
            end
        end
    end

    // A response leaving in a flush cycle still completes, so it is still counted.
    assign w_rsp_fire = r_s2_valid && rsp_ready_i && r_s2_fault;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fault_cnt <= '0;
        end else if (clr_cnt_i) begin
            r_fault_cnt <= '0;
        end else if (w_rsp_fire && (r_fault_cnt != 16'hFFFF)) begin
            r_fault_cnt <= r_fault_cnt + 16'd1;
        end
    end

    assign rsp_valid_o      = r_s2_valid;
    assign rsp_id_o         = r_s2_id;
    assign rsp_cacheable_o  = r_s2_cacheable;
    assign rsp_nonidem_o    = r_s2_nonidem;
    assign rsp_exec_o       = r_s2_exec;
    assign rsp_dspm_o       = r_s2_dspm;
    assign rsp_exec_fault_o = r_s2_fault;
    assign fault_cnt_o      = r_fault_cnt;

endmodule

// File: tb/tb_pma_attr_stage.sv
// Testbench for pma_attr_stage: directed scenarios plus a randomized stream checked
// against a rule-list reference model and an in-order scoreboard.
module tb_pma_attr_stage;
    import pma_attr_pkg::*;

    typedef struct packed {
        logic [3:0] id;
        logic       c;
        logic       n;
        logic       e;
        logic       d;
        logic       f;
    } rsp_t;

    localparam cva6_cfg_t TB_CFG = '{
        NrNonIdempotentRules:  32'd2,
        NonIdempotentAddrBase: {64'h0, 64'h0, 64'h1000_0000, 64'hFFFF_FFFF_0000_0000},
        NonIdempotentLength:   {64'h0, 64'h1000, 64'h0, 64'h1_0000_0000},
        NrExecuteRegionRules:  32'd1,
        ExecuteRegionAddrBase: {64'h0, 64'h0, 64'h1000_0000, 64'h8000_0000},
        ExecuteRegionLength:   {64'h0, 64'h0, 64'h1000, 64'h4000_0000},
        NrCachedRegionRules:   32'd2,
        CachedRegionAddrBase:  {64'h0, 64'h0, 64'h2000_0000, 64'h8000_0000},
        CachedRegionLength:    {64'h0, 64'h0, 64'h100, 64'h4000_0000},
        DcacheSpmEn:           1'b1,
        DcacheSpmBase:         56'h8000_0000,
        DcacheSpmLength:       56'h1_0000
    };

    localparam logic [63:0] EDGE_TBL [16] = '{
        64'h7FFF_FFFF, 64'h8000_0000, 64'h8000_FFFF, 64'h8001_0000,
        64'hBFFF_FFFF, 64'hC000_0000, 64'h1FFF_FFFF, 64'h2000_0000,
        64'h2000_00FF, 64'h2000_0100, 64'hFFFF_FFFE_FFFF_FFFF, 64'hFFFF_FFFF_0000_0000,
        64'hFFFF_FFFF_FFFF_FFFF, 64'h1000_0000, 64'h10, 64'h0
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_addr = '0;
    logic        req_fetch = 1'b0;
    logic [3:0]  req_id = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [3:0]  rsp_id;
    logic        rsp_c, rsp_n, rsp_e, rsp_d, rsp_f;
    logic        clr_cnt = 1'b0;
    logic [15:0] fault_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pma_attr_stage #(.CVA6Cfg(TB_CFG), .IdWidth(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_fetch_i(req_fetch), .req_id_i(req_id),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
        .rsp_cacheable_o(rsp_c), .rsp_nonidem_o(rsp_n), .rsp_exec_o(rsp_e),
        .rsp_dspm_o(rsp_d), .rsp_exec_fault_o(rsp_f),
        .clr_cnt_i(clr_cnt), .fault_cnt_o(fault_cnt)
    );

    function automatic rsp_t cur_rsp();
        return {rsp_id, rsp_c, rsp_n, rsp_e, rsp_d, rsp_f};
    endfunction

    function automatic bit in_rng(logic [63:0] a, logic [63:0] b, logic [63:0] l);
        return (a >= b) && ((a - b) < l);
    endfunction

    // Attributes straight from the rule lists: any listed window containing the address.
    function automatic rsp_t model(logic [63:0] a, logic f, logic [3:0] id);
        rsp_t r;
        bit   ca;
        r = '0;
        ca = 0;
        r.id = id;
        for (int k = 0; k < int'(TB_CFG.NrNonIdempotentRules) && k < NrMaxRules; k++)
            if (in_rng(a, TB_CFG.NonIdempotentAddrBase[k], TB_CFG.NonIdempotentLength[k])) r.n = 1'b1;
        if (TB_CFG.NrExecuteRegionRules == 0) r.e = 1'b1;
        for (int k = 0; k < int'(TB_CFG.NrExecuteRegionRules) && k < NrMaxRules; k++)
            if (in_rng(a, TB_CFG.ExecuteRegionAddrBase[k], TB_CFG.ExecuteRegionLength[k])) r.e = 1'b1;
        for (int k = 0; k < int'(TB_CFG.NrCachedRegionRules) && k < NrMaxRules; k++)
            if (in_rng(a, TB_CFG.CachedRegionAddrBase[k], TB_CFG.CachedRegionLength[k])) ca = 1;
        r.d = TB_CFG.DcacheSpmEn && in_rng(a, 64'(TB_CFG.DcacheSpmBase), 64'(TB_CFG.DcacheSpmLength));
        r.c = ca && !r.d;
        r.f = f && !r.e;
        return r;
    endfunction

    function automatic logic [63:0] pick_addr();
        if ($urandom_range(0, 4) == 0) return {$urandom, $urandom};
        return EDGE_TBL[$urandom_range(0, 15)];
    endfunction

    // Offer one request with rsp_ready high; lat = cycles from the accept cycle to rsp_valid.
    task automatic send_one(input logic [63:0] a, input logic f, input logic [3:0] id,
                            output rsp_t got, output int lat);
        int t;
        @(negedge clk);
        rsp_ready = 1'b1; req_valid = 1'b1; req_addr = a; req_fetch = f; req_id = id;
        #1;
        t = 0;
        while (!req_ready && t < 20) begin @(negedge clk); #1; t++; end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin @(negedge clk); lat++; end
        got = cur_rsp();
        $display("[TB] txn addr=%h fetch=%0d id=%0d rsp=%h lat=%0d", a, f, id, got, lat);
    endtask

    task automatic clear_cnt();
        @(negedge clk); clr_cnt = 1'b1;
        @(negedge clk); clr_cnt = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
        n_tests++; if (cur_rsp() !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", cur_rsp()); end
        n_tests++; if (fault_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt got=%h exp=0", fault_cnt); end
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_cache_edges();
        rsp_t got; int lat;
        send_one(64'hBFFF_FFFF, 1'b0, 4'h1, got, lat);
        n_tests++; if (got !== model(64'hBFFF_FFFF, 1'b0, 4'h1)) begin n_fail++; $display("FAIL edge_hi got=%h exp=%h", got, model(64'hBFFF_FFFF, 1'b0, 4'h1)); end
        n_tests++; if ({got.c, got.e, got.f} !== 3'b110) begin n_fail++; $display("FAIL edge_hi_bits got=%b exp=110", {got.c, got.e, got.f}); end
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL latency got=%0d exp=2", lat); end
        send_one(64'hC000_0000, 1'b0, 4'h2, got, lat);
        n_tests++; if (got !== model(64'hC000_0000, 1'b0, 4'h2)) begin n_fail++; $display("FAIL edge_end got=%h exp=%h", got, model(64'hC000_0000, 1'b0, 4'h2)); end
        n_tests++; if ({got.c, got.e} !== 2'b00) begin n_fail++; $display("FAIL edge_end_bits got=%b exp=00", {got.c, got.e}); end
    endtask

    task automatic test_boundaries();
        rsp_t got; int lat;
        logic [63:0] addrs [4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1000_0000, 64'h10, 64'hFFFF_FFFE_FFFF_FFFF};
        logic        exp_n [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            send_one(addrs[i], 1'b0, 4'(i + 8), got, lat);
            n_tests++; if (got !== model(addrs[i], 1'b0, 4'(i + 8)) || got.n !== exp_n[i]) begin
                n_fail++; $display("FAIL boundary_%0d got=%h exp=%h nonidem_exp=%b", i, got, model(addrs[i], 1'b0, 4'(i + 8)), exp_n[i]);
            end
        end
    endtask

    task automatic test_fetch_fault();
        rsp_t got; int lat;
        clear_cnt();
        send_one(64'h1000_0000, 1'b1, 4'h3, got, lat);
        n_tests++; if (got.f !== 1'b1 || got !== model(64'h1000_0000, 1'b1, 4'h3)) begin n_fail++; $display("FAIL fetch_fault got=%h exp=%h", got, model(64'h1000_0000, 1'b1, 4'h3)); end
        n_tests++; if (fault_cnt !== 16'd0) begin n_fail++; $display("FAIL cnt_before got=%0d exp=0", fault_cnt); end
        @(negedge clk);
        n_tests++; if (fault_cnt !== 16'd1) begin n_fail++; $display("FAIL cnt_after got=%0d exp=1", fault_cnt); end
        send_one(64'h1000_0000, 1'b0, 4'h4, got, lat);
        n_tests++; if (got.f !== 1'b0) begin n_fail++; $display("FAIL data_nofault got=%b exp=0", got.f); end
        @(negedge clk);
        n_tests++; if (fault_cnt !== 16'd1) begin n_fail++; $display("FAIL cnt_unchanged got=%0d exp=1", fault_cnt); end
    endtask

    task automatic test_dspm();
        rsp_t got; int lat;
        send_one(64'h8000_0100, 1'b0, 4'h5, got, lat);
        n_tests++; if ({got.d, got.c} !== 2'b10 || got !== model(64'h8000_0100, 1'b0, 4'h5)) begin n_fail++; $display("FAIL dspm_hit got=%h exp=%h", got, model(64'h8000_0100, 1'b0, 4'h5)); end
        send_one(64'h8001_0000, 1'b0, 4'h6, got, lat);
        n_tests++; if ({got.d, got.c} !== 2'b01 || got !== model(64'h8001_0000, 1'b0, 4'h6)) begin n_fail++; $display("FAIL dspm_end got=%h exp=%h", got, model(64'h8001_0000, 1'b0, 4'h6)); end
    endtask

    task automatic test_back_to_back();
        rsp_t exp_q[$]; rsp_t got_q[$]; rsp_t held; int t; bit sent3;
        logic [63:0] ad [3] = '{64'h8000_0000, 64'hC000_0000, 64'h1000_0000};
        for (int i = 0; i < 3; i++) exp_q.push_back(model(ad[i], (i == 2), 4'(i + 1)));
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = ad[0]; req_fetch = 1'b0; req_id = 4'd1; #1;
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_acc1 got=%b exp=1", req_ready); end
        @(negedge clk);
        req_addr = ad[1]; req_id = 4'd2; #1;
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_acc2 got=%b exp=1", req_ready); end
        @(negedge clk);
        req_addr = ad[2]; req_fetch = 1'b1; req_id = 4'd3; #1;
        n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full got=%b exp=0", req_ready); end
        held = cur_rsp();
        n_tests++; if (held !== exp_q[0] || rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_head got=%h exp=%h", held, exp_q[0]); end
        @(negedge clk); #1;
        n_tests++; if (cur_rsp() !== held || req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stable got=%h exp=%h", cur_rsp(), held); end
        @(negedge clk);
        rsp_ready = 1'b1;
        sent3 = 0; t = 0;
        while (got_q.size() < 3 && t < 12) begin
            #1;
            if (rsp_valid && rsp_ready) got_q.push_back(cur_rsp());
            if (req_valid && req_ready) sent3 = 1;
            @(negedge clk);
            if (sent3) req_valid = 1'b0;
            t++;
        end
        req_valid = 1'b0;
        n_tests++; if (got_q.size() !== 3) begin n_fail++; $display("FAIL bp_count got=%0d exp=3", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 3; i++) begin
            $display("[TB] bp rsp id=%0d rsp=%h", got_q[i].id, got_q[i]);
            n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_order_%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_flush();
        bit seen;
        clear_cnt();
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 64'h1000_0000; req_fetch = 1'b1; req_id = 4'd5;
        @(negedge clk);
        req_id = 4'd6;
        @(negedge clk);
        flush = 1'b1; req_id = 4'd7; rsp_ready = 1'b1; #1;
        n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got=%b exp=0", req_ready); end
        n_tests++; if (rsp_valid !== 1'b1 || rsp_id !== 4'd5) begin n_fail++; $display("FAIL flush_head got=%b/%0d exp=1/5", rsp_valid, rsp_id); end
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0; #1;
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop got=%b exp=0", rsp_valid); end
        n_tests++; if (fault_cnt !== 16'd1) begin n_fail++; $display("FAIL flush_cnt got=%0d exp=1", fault_cnt); end
        seen = 0;
        repeat (3) begin @(negedge clk); #1; if (rsp_valid) seen = 1; end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_ghost got=%b exp=0", seen); end
    endtask

    task automatic test_reset_midstream();
        bit seen;
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 64'h1000_0000; req_fetch = 1'b1; req_id = 4'd8;
        @(negedge clk);
        req_id = 4'd9;
        @(negedge clk);
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", rsp_valid); end
        n_tests++; if (cur_rsp() !== '0) begin n_fail++; $display("FAIL rst_data got=%h exp=0", cur_rsp()); end
        n_tests++; if (fault_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cnt got=%0d exp=0", fault_cnt); end
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
        @(negedge clk);
        rst_n = 1'b1; rsp_ready = 1'b1;
        seen = 0;
        repeat (3) begin @(negedge clk); #1; if (rsp_valid) seen = 1; end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_ghost got=%b exp=0", seen); end
    endtask

    task automatic test_random();
        rsp_t q[$]; rsp_t exp, got; int t;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            req_valid = ($urandom_range(0, 3) != 0);
            req_addr  = pick_addr();
            req_fetch = 1'($urandom_range(0, 1));
            req_id    = 4'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (rsp_valid && rsp_ready) begin
                got = cur_rsp();
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_extra got=%h exp=none", got);
                end else begin
                    exp = q.pop_front();
                    $display("[TB] rnd rsp=%h exp=%h", got, exp);
                    if (got !== exp) begin n_fail++; $display("FAIL rnd_rsp got=%h exp=%h", got, exp); end
                end
            end
            if (req_valid && req_ready) q.push_back(model(req_addr, req_fetch, req_id));
        end
        @(negedge clk);
        req_valid = 1'b0; rsp_ready = 1'b1;
        t = 0;
        while (q.size() > 0 && t < 20) begin
            #1;
            if (rsp_valid) begin
                got = cur_rsp(); exp = q.pop_front();
                n_tests++; if (got !== exp) begin n_fail++; $display("FAIL rnd_drain_rsp got=%h exp=%h", got, exp); end
            end
            @(negedge clk);
            t++;
        end
        n_tests++; if (q.size() != 0) begin n_fail++; $display("FAIL rnd_drain got=%0d left exp=0", q.size()); end
    endtask

    task automatic test_saturation();
        int acc, hs, t; rsp_t got; int lat;
        clear_cnt();
        acc = 0; hs = 0; t = 0;
        rsp_ready = 1'b1; req_addr = 64'h1000_0000; req_fetch = 1'b1;
        while ((acc < 65535 || hs < 65535) && t < 70000) begin
            @(negedge clk);
            req_valid = (acc < 65535);
            req_id = 4'(acc);
            #1;
            if (rsp_valid && rsp_ready) hs++;
            if (req_valid && req_ready) acc++;
            t++;
        end
        @(negedge clk);
        req_valid = 1'b0; #1;
        n_tests++; if (hs !== 65535) begin n_fail++; $display("FAIL sat_stream got=%0d exp=65535", hs); end
        n_tests++; if (fault_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_preload got=%h exp=ffff", fault_cnt); end
        send_one(64'h1000_0000, 1'b1, 4'hA, got, lat);
        @(negedge clk);
        n_tests++; if (fault_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got=%h exp=ffff", fault_cnt); end
        send_one(64'h1000_0000, 1'b1, 4'hB, got, lat);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        n_tests++; if (got.f !== 1'b1 || fault_cnt !== 16'h0) begin n_fail++; $display("FAIL clr_priority got=%h/%b exp=0/1", fault_cnt, got.f); end
    endtask

    initial begin
        #1_200_000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cache_edges();
        test_boundaries();
        test_fetch_fault();
        test_dspm();
        test_back_to_back();
        test_flush();
        test_reset_midstream();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
